pipeline_debug_sequencer: RTL and testbench

Sequences the five-stage MIPS pipeline under host control for debug and bring-up. It accepts command bytes from a byte-stream receiver and drives the global pipeline advance enable and flush: run-to-halt, single-step, dump, or flush. It then serializes PC, an executed-cycle counter and the whole register file (the ID stage's 32×32 debug bus) onto a byte-stream transmitter. It sits between the UART byte interfaces and the pipeline top level.

---
 rtl/pipeline_debug_sequencer_if.sv | 29 ++
 rtl/pipeline_debug_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_pipeline_debug_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_debug_sequencer_if.sv
// Byte-stream and pipeline-control bundle between the UART byte engines,
// the debug sequencer and the five-stage pipeline top level.
interface pipeline_debug_sequencer_if #(
    parameter int unsigned REG_COUNT = 32
);
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic                    rx_ready;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    halt;
    logic [31:0]             pc;
    logic [32*REG_COUNT-1:0] reg_bus;
    logic                    pipe_enable;
    logic                    pipe_flush;

    // Sequencer side
    modport master (
        input  rx_data, rx_valid, tx_ready, halt, pc, reg_bus,
        output rx_ready, tx_data, tx_valid, pipe_enable, pipe_flush
    );

    // UART / pipeline side
    modport slave (
        output rx_data, rx_valid, tx_ready, halt, pc, reg_bus,
        input  rx_ready, tx_data, tx_valid, pipe_enable, pipe_flush
    );
endinterface

// File: rtl/pipeline_debug_sequencer.sv
// Host-driven debug sequencer: runs, steps or flushes the pipeline on command
// bytes and streams PC, cycle count and the register file out as a byte frame.
module pipeline_debug_sequencer #(
    parameter int unsigned REG_COUNT = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    pipeline_debug_sequencer_if.master bus,
    output logic [2:0]                 state_o
);
    localparam int unsigned FRAME_BYTES = 8 + 4 * REG_COUNT;
    localparam int unsigned FRAME_WORDS = REG_COUNT + 2;
    localparam int unsigned IDX_W       = $clog2(FRAME_BYTES);
    localparam int unsigned WORD_W      = IDX_W - 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_DUMP  = 8'h44;
    localparam logic [7:0] CMD_FLUSH = 8'h46;
    localparam logic [7:0] ACK_BYTE  = 8'h4B;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DUMP  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_ACK   = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       cycle_q, cycle_d;
    logic              rx_ready_q, rx_ready_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              flush_q, flush_d;

    logic              pipe_enable_c;
    logic              rx_fire_c;
    logic              tx_fire_c;
    logic [IDX_W-1:0]  idx_inc_c;
    logic [WORD_W-1:0] sel_word_c;
    logic [1:0]        sel_byte_c;
    logic [31:0]       words_c [FRAME_WORDS];
    logic [31:0]       word_c;
    logic [7:0]        next_byte_c;

    assign pipe_enable_c = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bus.halt;
    assign rx_fire_c     = bus.rx_valid && rx_ready_q;
    assign tx_fire_c     = tx_valid_q && bus.tx_ready;
    assign idx_inc_c     = idx_q + IDX_W'(1);
    assign sel_word_c    = idx_inc_c[IDX_W-1:2];
    assign sel_byte_c    = idx_inc_c[1:0];

    // Frame word order: PC, cycle count, then registers 0..REG_COUNT-1
    always_comb begin
        words_c[0] = bus.pc;
        words_c[1] = cycle_q;
        for (int unsigned k = 0; k < REG_COUNT; k++) begin
            words_c[k+2] = bus.reg_bus[32*k +: 32];
        end
    end

    // Live mux of the byte following the current index, MSB first within a word
    always_comb begin
        word_c = '0;
        for (int unsigned k = 0; k < FRAME_WORDS; k++) begin
            if (sel_word_c == WORD_W'(k)) begin
                word_c = words_c[k];
            end
        end
        unique case (sel_byte_c)
            2'd0:    next_byte_c = word_c[31:24];
            2'd1:    next_byte_c = word_c[23:16];
            2'd2:    next_byte_c = word_c[15:8];
            default: next_byte_c = word_c[7:0];
        endcase
    end

    // Registered outputs are computed for the state being entered
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cycle_d    = pipe_enable_c ? cycle_q + 32'd1 : cycle_q;
        rx_ready_d = 1'b0;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        flush_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                rx_ready_d = 1'b1;
                if (rx_fire_c) begin
                    unique case (bus.rx_data)
                        CMD_RUN: begin
                            state_d    = ST_RUN;
                            rx_ready_d = 1'b0;
                        end
                        CMD_STEP: begin
                            state_d    = ST_STEP;
                            rx_ready_d = 1'b0;
                        end
                        CMD_DUMP: begin
                            state_d    = ST_DUMP;
                            rx_ready_d = 1'b0;
                            idx_d      = '0;
                            tx_valid_d = 1'b1;
                            tx_data_d  = bus.pc[31:24];
                        end
                        CMD_FLUSH: begin
                            state_d    = ST_FLUSH;
                            rx_ready_d = 1'b0;
                            flush_d    = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            ST_RUN: begin
                if (bus.halt) begin
                    state_d    = ST_DUMP;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = bus.pc[31:24];
                end
            end

            ST_STEP: begin
                state_d    = ST_DUMP;
                idx_d      = '0;
                tx_valid_d = 1'b1;
                tx_data_d  = bus.pc[31:24];
            end

            ST_DUMP: begin
                tx_valid_d = 1'b1;
                tx_data_d  = tx_data_q;
                if (tx_fire_c) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = ST_IDLE;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                        rx_ready_d = 1'b1;
                    end else begin
                        idx_d     = idx_inc_c;
                        tx_data_d = next_byte_c;
                    end
                end
            end

            ST_FLUSH: begin
                cycle_d    = '0;
                state_d    = ST_ACK;
                tx_valid_d = 1'b1;
                tx_data_d  = ACK_BYTE;
            end

            ST_ACK: begin
                tx_valid_d = 1'b1;
                tx_data_d  = tx_data_q;
                if (tx_fire_c) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    rx_ready_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cycle_q    <= '0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cycle_q    <= cycle_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            flush_q    <= flush_d;
        end
    end

    assign bus.rx_ready    = rx_ready_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.pipe_flush  = flush_q;
    assign bus.pipe_enable = pipe_enable_c;
    assign state_o         = 3'(state_q);

endmodule

// File: tb/tb_pipeline_debug_sequencer.sv
// Scoreboard bench for pipeline_debug_sequencer: expected Tx bytes are queued
// at command time and checked by an independent monitor on every transfer.
module tb_pipeline_debug_sequencer;
    localparam int unsigned REGS  = 32;
    localparam int unsigned FRAME = 8 + 4 * REGS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  state;
    logic [31:0] regs [REGS];
    int          rdy_mode;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;
    int fl_cnt   = 0;
    int vcyc     = 0;
    int byte_cnt = 0;
    logic [7:0] sb [$];

    pipeline_debug_sequencer_if #(.REG_COUNT(REGS)) ifc ();

    pipeline_debug_sequencer #(.REG_COUNT(REGS)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifc),
        .state_o(state)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < REGS; k++) ifc.reg_bus[32*k +: 32] = regs[k];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected frame: PC, cycle count, then each register, MSB first
    task automatic push_frame(input logic [31:0] cnt);
        logic [31:0] w;
        for (int i = 0; i < REGS + 2; i++) begin
            w = (i == 0) ? ifc.pc : (i == 1) ? cnt : regs[i-2];
            sb.push_back(w[31:24]);
            sb.push_back(w[23:16]);
            sb.push_back(w[15:8]);
            sb.push_back(w[7:0]);
        end
    endtask

    // TxReady driver: 0 = always ready, 1 = random, 2 = never ready
    initial begin
        ifc.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                1:       ifc.tx_ready = 1'($urandom_range(0, 1));
                2:       ifc.tx_ready = 1'b0;
                default: ifc.tx_ready = 1'b1;
            endcase
        end
    end

    // Monitor: counts enable/flush cycles, checks Tx bytes and stall stability
    logic       stalled = 1'b0;
    logic [7:0] held    = 8'h00;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.pipe_enable) en_cnt++;
            if (ifc.pipe_flush)  fl_cnt++;
            if (ifc.tx_valid)    vcyc++;
            if (stalled && ifc.tx_valid) check("tx_hold", 32'(ifc.tx_data), 32'(held));
            stalled = ifc.tx_valid && !ifc.tx_ready;
            held    = ifc.tx_data;
            if (ifc.tx_valid && ifc.tx_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got %02h with nothing expected", ifc.tx_data);
                end else begin
                    check("tx_byte", 32'(ifc.tx_data), 32'(sb.pop_front()));
                end
                byte_cnt++;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic send_cmd(input logic [7:0] b);
        bit done = 0;
        @(posedge clk);
        #1;
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            if (ifc.rx_ready) begin
                @(posedge clk);
                #1;
                ifc.rx_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) begin
            ifc.rx_valid = 1'b0;
            check("cmd_accept_timeout", 32'(0), 32'(1));
        end
    endtask

    // Waits for the scoreboard to drain, then checks the return to IDLE
    task automatic wait_done(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check({name, "_drain"}, 32'(sb.size()), 32'(0));
        @(negedge clk);
        check({name, "_txv_end"}, 32'(ifc.tx_valid), 32'(0));
        check({name, "_rxr_end"}, 32'(ifc.rx_ready), 32'(1));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int base;
        rdy_mode     = 0;
        rst_n        = 1'b0;
        ifc.rx_data  = 8'h00;
        ifc.rx_valid = 1'b0;
        ifc.halt     = 1'b0;
        ifc.pc       = 32'h0000_0040;
        for (int k = 0; k < REGS; k++) regs[k] = {8'(k), 8'hA5, 8'(k + 8'h10), 8'h5A};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state), 32'(0));
        check("rst_rx_ready", 32'(ifc.rx_ready), 32'(0));
        check("rst_tx_valid", 32'(ifc.tx_valid), 32'(0));
        check("rst_tx_data", 32'(ifc.tx_data), 32'(0));
        check("rst_flush", 32'(ifc.pipe_flush), 32'(0));
        check("rst_enable", 32'(ifc.pipe_enable), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rx_ready_after_rst", 32'(ifc.rx_ready), 32'(1));

        // Plain dump: 136 back-to-back bytes, PC=0x40, count 0
        push_frame(32'd0);
        base = vcyc;
        send_cmd(8'h44);
        @(negedge clk);
        check("dump_state", 32'(state), 32'(3));
        check("dump_first_valid", 32'(ifc.tx_valid), 32'(1));
        check("dump_first_byte", 32'(ifc.tx_data), 32'(8'h00));
        wait_done("dump1");
        check("dump1_len", 32'(vcyc - base), 32'(FRAME));

        // Three single steps
        for (int n = 1; n <= 3; n++) begin
            push_frame(32'(n));
            base = en_cnt;
            send_cmd(8'h53);
            if (n == 1) begin
                @(negedge clk);
                check("step_state", 32'(state), 32'(2));
                check("step_enable", 32'(ifc.pipe_enable), 32'(1));
            end
            wait_done("step");
            check("step_pulses", 32'(en_cnt - base), 32'(1));
        end

        // Run until Halt rises after 10 advances (count 3 -> 13)
        ifc.pc = 32'h0000_1234;
        push_frame(32'd13);
        base = en_cnt;
        send_cmd(8'h52);
        repeat (10) @(posedge clk);
        #1 ifc.halt = 1'b1;
        wait_done("run");
        check("run_advances", 32'(en_cnt - base), 32'(10));

        // Run with Halt already set: no advance, count unchanged
        push_frame(32'd13);
        base = en_cnt;
        send_cmd(8'h52);
        wait_done("run_halted");
        check("run_halted_advances", 32'(en_cnt - base), 32'(0));

        // Flush: one PipeFlush cycle, ack byte, count cleared
        ifc.halt = 1'b0;
        sb.push_back(8'h4B);
        base = fl_cnt;
        send_cmd(8'h46);
        @(negedge clk);
        check("flush_state", 32'(state), 32'(4));
        check("flush_pulse", 32'(ifc.pipe_flush), 32'(1));
        wait_done("ack");
        check("flush_cycles", 32'(fl_cnt - base), 32'(1));
        push_frame(32'd0);
        send_cmd(8'h44);
        wait_done("dump_after_flush");

        // Dump under random backpressure, different data
        ifc.pc = 32'hDEAD_BEEF;
        for (int k = 0; k < REGS; k++) regs[k] = ~regs[k] ^ 32'(k * 32'h0101_0101);
        rdy_mode = 1;
        push_frame(32'd0);
        send_cmd(8'h44);
        wait_done("dump_random");
        rdy_mode = 0;

        // Unknown byte is consumed and ignored
        send_cmd(8'h00);
        @(negedge clk);
        check("unknown_state", 32'(state), 32'(0));
        check("unknown_rx_ready", 32'(ifc.rx_ready), 32'(1));
        check("unknown_no_tx", 32'(ifc.tx_valid), 32'(0));

        // Reset mid-dump at byte 50, then a fresh complete frame
        push_frame(32'd0);
        base = byte_cnt;
        send_cmd(8'h44);
        for (int t = 0; t < 1000 && (byte_cnt - base) < 50; t++) @(posedge clk);
        check("reached_byte50", 32'(byte_cnt - base), 32'd50);
        #1;
        rst_n    = 1'b0;
        rdy_mode = 2;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_tx_valid", 32'(ifc.tx_valid), 32'(0));
        check("mid_rst_state", 32'(state), 32'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rdy_mode = 0;
        push_frame(32'd0);
        base = byte_cnt;
        send_cmd(8'h44);
        wait_done("dump_after_rst");
        check("dump_after_rst_len", 32'(byte_cnt - base), 32'(FRAME));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
